// File: rtl/fll_bus_bridge.sv
// Bridges one upstream req/ack config port to NUM_FLL downstream FLL config ports.
// Per-access timeout with error response, plus a per-channel lock synchroniser.
module fll_bus_bridge #(
    parameter int NUM_FLL     = 2,
    parameter int REG_AW      = 2,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2,
    localparam int CHW        = (NUM_FLL > 1) ? $clog2(NUM_FLL) : 1,
    localparam int AW         = CHW + REG_AW
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  up_req_i,
    input  logic                  up_wrn_i,
    input  logic [AW-1:0]         up_addr_i,
    input  logic [DW-1:0]         up_wdata_i,
    output logic                  up_ack_o,
    output logic [DW-1:0]         up_rdata_o,
    output logic                  up_err_o,
    output logic [NUM_FLL-1:0]    lock_o,
    output logic                  lock_all_o,
    output logic [NUM_FLL-1:0]    fll_req_o,
    output logic                  fll_wrn_o,
    output logic [REG_AW-1:0]     fll_addr_o,
    output logic [DW-1:0]         fll_wdata_o,
    input  logic [NUM_FLL-1:0]    fll_ack_i,
    input  logic [NUM_FLL*DW-1:0] fll_rdata_i,
    input  logic [NUM_FLL-1:0]    fll_lock_i
);

    localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_LAST = (TIMEOUT > 0) ? CNTW'(TIMEOUT - 1) : {CNTW{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_RESP     = 3'd2,
        ST_ERR      = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_e;

    state_e state_r, next_state_s;

    logic [CHW-1:0]     sel_r, sel_nxt_s;
    logic [NUM_FLL-1:0] fll_req_r, fll_req_nxt_s;
    logic               fll_wrn_r, fll_wrn_nxt_s;
    logic [REG_AW-1:0]  fll_addr_r, fll_addr_nxt_s;
    logic [DW-1:0]      fll_wdata_r, fll_wdata_nxt_s;
    logic               up_ack_r, up_ack_nxt_s;
    logic               up_err_r, up_err_nxt_s;
    logic [DW-1:0]      up_rdata_r, up_rdata_nxt_s;
    logic [CNTW-1:0]    cnt_r, cnt_nxt_s;

    logic [CHW-1:0]     ch_s;
    logic               ch_ok_s;
    logic               ack_sel_s;
    logic [DW-1:0]      rdata_sel_s;
    logic               timeout_s;

    logic [NUM_FLL-1:0] sync_r [SYNC_STAGES];

    function automatic logic [NUM_FLL-1:0] ch_onehot(input logic [CHW-1:0] ch);
        logic [NUM_FLL-1:0] oh;
        oh = {NUM_FLL{1'b0}};
        for (int i = 0; i < NUM_FLL; i++) begin
            oh[i] = (ch == CHW'(i));
        end
        return oh;
    endfunction

    assign ch_s      = up_addr_i[AW-1:REG_AW];
    assign ch_ok_s   = (32'(ch_s) < 32'(NUM_FLL));
    assign timeout_s = (TIMEOUT != 0) && (cnt_r == CNT_LAST);

    // Route the ack and read data of the selected channel only; others are ignored.
    always_comb begin
        ack_sel_s   = 1'b0;
        rdata_sel_s = {DW{1'b0}};
        for (int i = 0; i < NUM_FLL; i++) begin
            if (sel_r == CHW'(i)) begin
                ack_sel_s   = fll_ack_i[i];
                rdata_sel_s = fll_rdata_i[i*DW +: DW];
            end else begin
                ack_sel_s   = ack_sel_s;
                rdata_sel_s = rdata_sel_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; ack beats expiry when both occur together.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (up_req_i) begin
                    next_state_s = ch_ok_s ? ST_REQ : ST_ERR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_sel_s) begin
                    next_state_s = ST_RESP;
                end else if (timeout_s) begin
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_RESP:     next_state_s = ST_WAIT_REL;
            ST_ERR:      next_state_s = ST_WAIT_REL;
            ST_WAIT_REL: begin
                if (!up_req_i) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT_REL;
                end
            end
            default:     next_state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; the ack pulse is raised on entry to RESP/ERR.
    always_comb begin
        sel_nxt_s       = sel_r;
        fll_req_nxt_s   = fll_req_r;
        fll_wrn_nxt_s   = fll_wrn_r;
        fll_addr_nxt_s  = fll_addr_r;
        fll_wdata_nxt_s = fll_wdata_r;
        up_ack_nxt_s    = 1'b0;
        up_err_nxt_s    = 1'b0;
        up_rdata_nxt_s  = up_rdata_r;
        cnt_nxt_s       = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = {CNTW{1'b0}};
                if (up_req_i) begin
                    sel_nxt_s       = ch_s;
                    fll_wrn_nxt_s   = up_wrn_i;
                    fll_addr_nxt_s  = up_addr_i[REG_AW-1:0];
                    fll_wdata_nxt_s = up_wdata_i;
                    if (ch_ok_s) begin
                        fll_req_nxt_s = ch_onehot(ch_s);
                    end else begin
                        up_ack_nxt_s   = 1'b1;
                        up_err_nxt_s   = 1'b1;
                        up_rdata_nxt_s = {DW{1'b0}};
                    end
                end else begin
                    fll_req_nxt_s = {NUM_FLL{1'b0}};
                end
            end
            ST_REQ: begin
                if (cnt_r != CNT_MAX) begin
                    cnt_nxt_s = cnt_r + CNTW'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                if (ack_sel_s) begin
                    fll_req_nxt_s  = {NUM_FLL{1'b0}};
                    up_ack_nxt_s   = 1'b1;
                    up_rdata_nxt_s = rdata_sel_s;
                end else if (timeout_s) begin
                    fll_req_nxt_s  = {NUM_FLL{1'b0}};
                    up_ack_nxt_s   = 1'b1;
                    up_err_nxt_s   = 1'b1;
                    up_rdata_nxt_s = {DW{1'b0}};
                end else begin
                    fll_req_nxt_s = fll_req_r;
                end
            end
            default: begin
                fll_req_nxt_s = {NUM_FLL{1'b0}};
            end
        endcase
    end

    // Output and capture registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_r       <= {CHW{1'b0}};
            fll_req_r   <= {NUM_FLL{1'b0}};
            fll_wrn_r   <= 1'b0;
            fll_addr_r  <= {REG_AW{1'b0}};
            fll_wdata_r <= {DW{1'b0}};
            up_ack_r    <= 1'b0;
            up_err_r    <= 1'b0;
            up_rdata_r  <= {DW{1'b0}};
            cnt_r       <= {CNTW{1'b0}};
        end else begin
            sel_r       <= sel_nxt_s;
            fll_req_r   <= fll_req_nxt_s;
            fll_wrn_r   <= fll_wrn_nxt_s;
            fll_addr_r  <= fll_addr_nxt_s;
            fll_wdata_r <= fll_wdata_nxt_s;
            up_ack_r    <= up_ack_nxt_s;
            up_err_r    <= up_err_nxt_s;
            up_rdata_r  <= up_rdata_nxt_s;
            cnt_r       <= cnt_nxt_s;
        end
    end

    // Lock synchroniser chain, free-running and independent of the FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= {NUM_FLL{1'b0}};
            end
        end else begin
            sync_r[0] <= fll_lock_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign fll_req_o   = fll_req_r;
    assign fll_wrn_o   = fll_wrn_r;
    assign fll_addr_o  = fll_addr_r;
    assign fll_wdata_o = fll_wdata_r;
    assign up_ack_o    = up_ack_r;
    assign up_err_o    = up_err_r;
    assign up_rdata_o  = up_rdata_r;
    assign lock_o      = sync_r[SYNC_STAGES-1];
    assign lock_all_o  = &sync_r[SYNC_STAGES-1];

endmodule
